// File: rtl/axis_mag_keep_n.sv
// Per-channel complex magnitude with a delay-matched raw-beat bypass, both framed by tlast.
// Optional build macro AXIS_MAG_ROUND_EN: round the magnitude to nearest instead of floor.
module axis_mag_keep_n #(
    parameter int NCH       = 2,
    parameter int DW        = 32,
    parameter int FRAME_LEN = 4096
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    input  logic [NCH*2*DW-1:0]   s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    output logic [NCH*DW-1:0]     m00_axis_tdata,
    output logic                  m00_axis_tvalid,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic [NCH*2*DW-1:0]   m01_axis_tdata,
    output logic                  m01_axis_tvalid,
    output logic                  m01_axis_tlast,
    input  logic                  m01_axis_tready
);

    localparam int BW = NCH * 2 * DW;
    localparam int MW = NCH * DW;
    localparam int ND = DW + 3;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DW-1:0] MAG_ONE  = DW'(1);

    logic            adv;
    logic            retire;
    logic            out_valid_q;
    logic [CW-1:0]   frame_cnt_q;
    logic [ND-1:0]   vld_q;

    // raw_q[0] is the S0 input register; raw_q[i] travels alongside stage i.
    logic [BW-1:0]   raw_q   [ND];
    logic [2*DW-1:0] sq_re_q [NCH];
    logic [2*DW-1:0] sq_im_q [NCH];
    logic [2*DW-1:0] sq_re_d [NCH];
    logic [2*DW-1:0] sq_im_d [NCH];
    logic [2*DW-1:0] sum_q   [NCH];

    logic [DW-1:0]   root_q  [DW][NCH];
    logic [DW-1:0]   root_d  [DW][NCH];
    logic [DW+1:0]   rem_q   [DW][NCH];
    logic [DW+1:0]   rem_d   [DW][NCH];
    logic [2*DW-1:0] rad_q   [DW][NCH];
    logic [2*DW-1:0] rad_d   [DW][NCH];

    logic [MW-1:0]   mag_d;

    assign adv    = !out_valid_q || (m00_axis_tready && m01_axis_tready);
    assign retire = out_valid_q && m00_axis_tready && m01_axis_tready;

    assign s00_axis_tready = adv;
    assign m00_axis_tvalid = out_valid_q;
    assign m01_axis_tvalid = out_valid_q;
    assign m00_axis_tlast  = out_valid_q && (frame_cnt_q == LAST_CNT);
    assign m01_axis_tlast  = out_valid_q && (frame_cnt_q == LAST_CNT);

    // Sign-extend to 2DW so the truncated product equals the exact non-negative square.
    always_comb begin
        logic [2*DW-1:0] re_x;
        logic [2*DW-1:0] im_x;
        re_x = '0;
        im_x = '0;
        for (int k = 0; k < NCH; k++) begin
            re_x = {{DW{raw_q[0][k*2*DW + 2*DW - 1]}}, raw_q[0][k*2*DW + DW +: DW]};
            im_x = {{DW{raw_q[0][k*2*DW + DW - 1]}},   raw_q[0][k*2*DW +: DW]};
            sq_re_d[k] = re_x * re_x;
            sq_im_d[k] = im_x * im_x;
        end
    end

    // Restoring square root: stage j resolves root bit DW-1-j from radicand bits [2i+1:2i].
    always_comb begin
        logic [DW-1:0]   root_p;
        logic [DW+1:0]   rem_p;
        logic [2*DW-1:0] rad_p;
        logic [DW+3:0]   rem_sh;
        logic [DW+3:0]   trial;
        root_p = '0;
        rem_p  = '0;
        rad_p  = '0;
        rem_sh = '0;
        trial  = '0;
        for (int j = 0; j < DW; j++) begin
            for (int k = 0; k < NCH; k++) begin
                if (j == 0) begin
                    root_p = '0;
                    rem_p  = '0;
                    rad_p  = sum_q[k];
                end else begin
                    root_p = root_q[j-1][k];
                    rem_p  = rem_q[j-1][k];
                    rad_p  = rad_q[j-1][k];
                end
                rem_sh = {rem_p, rad_p[2*(DW-1-j) +: 2]};
                trial  = {2'b00, root_p, 2'b01};
                if (rem_sh >= trial) begin
                    rem_sh       = rem_sh - trial;
                    root_d[j][k] = {root_p[DW-2:0], 1'b1};
                end else begin
                    root_d[j][k] = {root_p[DW-2:0], 1'b0};
                end
                rem_d[j][k] = rem_sh[DW+1:0];
                rad_d[j][k] = rad_p;
            end
        end
    end

    // Final remainder is sum - r^2, so sum > r^2 + r reduces to rem > r.
    always_comb begin
        logic [DW-1:0] r;
        mag_d = '0;
        r     = '0;
        for (int k = 0; k < NCH; k++) begin
            r = root_q[DW-1][k];
`ifdef AXIS_MAG_ROUND_EN
            if ((rem_q[DW-1][k] > {2'b00, r}) && (r != {DW{1'b1}}))
                mag_d[k*DW +: DW] = r + MAG_ONE;
            else
                mag_d[k*DW +: DW] = r;
`else
            mag_d[k*DW +: DW] = r;
`endif
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (adv) begin
            raw_q[0] <= s00_axis_tdata;
            for (int i = 1; i < ND; i++)
                raw_q[i] <= raw_q[i-1];
            for (int k = 0; k < NCH; k++) begin
                sq_re_q[k] <= sq_re_d[k];
                sq_im_q[k] <= sq_im_d[k];
                sum_q[k]   <= sq_re_q[k] + sq_im_q[k];
            end
            for (int j = 0; j < DW; j++) begin
                for (int k = 0; k < NCH; k++) begin
                    root_q[j][k] <= root_d[j][k];
                    rem_q[j][k]  <= rem_d[j][k];
                    rad_q[j][k]  <= rad_d[j][k];
                end
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            vld_q          <= '0;
            out_valid_q    <= 1'b0;
            m00_axis_tdata <= '0;
            m01_axis_tdata <= '0;
            frame_cnt_q    <= '0;
        end else begin
            if (adv) begin
                vld_q       <= {vld_q[ND-2:0], s00_axis_tvalid};
                out_valid_q <= vld_q[ND-1];
                if (vld_q[ND-1]) begin
                    m00_axis_tdata <= mag_d;
                    m01_axis_tdata <= raw_q[ND-1];
                end
            end
            if (retire)
                frame_cnt_q <= frame_cnt_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_axis_mag_keep_n.sv
// Scoreboard bench for axis_mag_keep_n (NCH=2, DW=32, FRAME_LEN=8).
module tb_axis_mag_keep_n;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int FL  = 8;
    localparam int LAT = DW + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [63:0]  m00_tdata;
    logic         m00_tvalid, m00_tlast, m00_tready;
    logic [127:0] m01_tdata;
    logic         m01_tvalid, m01_tlast, m01_tready;

    axis_mag_keep_n #(.NCH(NCH), .DW(DW), .FRAME_LEN(FL)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m00_tdata),
        .m00_axis_tvalid (m00_tvalid),
        .m00_axis_tlast  (m00_tlast),
        .m00_axis_tready (m00_tready),
        .m01_axis_tdata  (m01_tdata),
        .m01_axis_tvalid (m01_tvalid),
        .m01_axis_tlast  (m01_tlast),
        .m01_axis_tready (m01_tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]  mag;
        logic [127:0] raw;
        logic         last;
        int           acc;
        bit           chk;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   push_idx = 0;
    bit   lat_mode = 1'b1;
    int   rdy_mode = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] re0, input logic [31:0] im0,
                                        input logic [31:0] re1, input logic [31:0] im1);
        return {re1, im1, re0, im0};
    endfunction

    task automatic check_rst(input string tag);
        check({tag, "_m00_tvalid"}, 128'(m00_tvalid), 128'(0));
        check({tag, "_m01_tvalid"}, 128'(m01_tvalid), 128'(0));
        check({tag, "_m00_tlast"},  128'(m00_tlast),  128'(0));
        check({tag, "_m01_tlast"},  128'(m01_tlast),  128'(0));
        check({tag, "_m00_tdata"},  128'(m00_tdata),  128'(0));
        check({tag, "_m01_tdata"},  m01_tdata,        128'(0));
        check({tag, "_s00_tready"}, 128'(s_tready),   128'(1));
    endtask

    // Entered and left at posedge+1; holds the beat until the DUT takes it.
    task automatic send(input logic [127:0] beat, input logic [63:0] mag, input int gap);
        int  budget;
        bit  done;
        exp_t e;
        budget = 2000;
        done   = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = beat;
        while (!done) begin
            @(negedge clk);
            if (s_tready) begin
                e.mag  = mag;
                e.raw  = beat;
                e.last = ((push_idx % FL) == FL - 1);
                e.acc  = cyc;
                e.chk  = lat_mode;
                sbq.push_back(e);
                push_idx++;
                done = 1'b1;
            end else begin
                budget--;
                if (budget == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_timeout: beat %h not accepted", beat);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m00_tready = 1'b1;
        m01_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                m00_tready = 1'b1;
                m01_tready = 1'b1;
            end else begin
                m00_tready = 1'($urandom_range(0, 1));
                m01_tready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Output monitor: pops the scoreboard on every retired beat.
    initial begin
        exp_t         e;
        bit           stalled_prev;
        logic [63:0]  held_mag;
        logic [127:0] held_raw;
        logic         held_last;
        stalled_prev = 1'b0;
        held_mag = '0;
        held_raw = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                check("valid_match", 128'(m01_tvalid), 128'(m00_tvalid));
                check("s00_tready", 128'(s_tready),
                      128'(!(m00_tvalid && !(m00_tready && m01_tready))));
                if (stalled_prev) begin
                    check("stall_valid", 128'(m00_tvalid), 128'(1));
                    check("stall_m00_data", 128'(m00_tdata), 128'(held_mag));
                    check("stall_m01_data", m01_tdata, held_raw);
                    check("stall_last", 128'(m00_tlast), 128'(held_last));
                end
                if (m00_tvalid && m00_tready && m01_tready) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_valid: output beat %h with empty scoreboard", m00_tdata);
                    end else begin
                        e = sbq.pop_front();
                        check("m00_tdata", 128'(m00_tdata), 128'(e.mag));
                        check("m01_tdata", m01_tdata, e.raw);
                        check("m00_tlast", 128'(m00_tlast), 128'(e.last));
                        check("m01_tlast", 128'(m01_tlast), 128'(e.last));
                        if (e.chk)
                            check("latency", 128'(cyc - e.acc), 128'(LAT));
                    end
                end
                stalled_prev = m00_tvalid && !(m00_tready && m01_tready);
                held_mag  = m00_tdata;
                held_raw  = m01_tdata;
                held_last = m00_tlast;
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        #1;
        check_rst("init");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic value and latency
        send(mk(32'd3, 32'd4, -32'sd5, 32'd12), {32'd13, 32'd5}, 0);
        drain();

        // Directed values, back to back
`ifdef AXIS_MAG_ROUND_EN
        send(mk(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
             {32'hB504_F333, 32'hB504_F334}, 0);
        send(mk(32'd2, 32'd3, 32'd1, 32'd1), {32'd1, 32'd4}, 0);
`else
        send(mk(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
             {32'hB504_F332, 32'hB504_F333}, 0);
        send(mk(32'd2, 32'd3, 32'd1, 32'd1), {32'd1, 32'd3}, 0);
`endif
        send(mk(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0), {32'd1, 32'd0}, 0);
        send(mk(32'd0, -32'sd7, 32'd6, -32'sd8), {32'd10, 32'd7}, 0);
        drain();

        // Input bubbles: one beat every third cycle
        for (int n = 1; n <= 6; n++)
            send(mk(32'(3*n), 32'(4*n), 32'(-5*n), 32'(12*n)), {32'(13*n), 32'(5*n)}, 2);
        drain();

        // Backpressure ramp with independent random sink readies
        lat_mode = 1'b0;
        rdy_mode = 1;
        for (int n = 1; n <= 100; n++)
            send(mk(32'(3*n), 32'(4*n), 32'(-5*n), 32'(12*n)), {32'(13*n), 32'(5*n)}, 0);
        // Framing under stalls and bubbles
        for (int n = 101; n <= 120; n++)
            send(mk(32'(3*n), 32'(4*n), 32'(-5*n), 32'(12*n)), {32'(13*n), 32'(5*n)}, (n % 3 == 0) ? 1 : 0);
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        lat_mode = 1'b1;

        // Reset with 10 beats in flight
        for (int n = 1; n <= 10; n++)
            send(mk(32'(3*n), 32'(4*n), 32'(-5*n), 32'(12*n)), {32'(13*n), 32'(5*n)}, 0);
        #2;
        rst = 1'b1;
        #1;
        check_rst("midrst");
        sbq.delete();
        push_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 200; n < 210; n++)
            send(mk(32'(3*n), 32'(4*n), 32'(-5*n), 32'(12*n)), {32'(13*n), 32'(5*n)}, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_mag_keep_n.md
Name: axis_mag_keep_n

Overview:
- Parametrised successor to the two-channel magnitude/keep splitter in the DOA front end.
- Accepts NCH complex channels per AXIS beat and computes the integer magnitude floor(sqrt(re^2+im^2)) per channel with an in-block pipelined square root.
- Forwards the raw beat, delay-matched, alongside the magnitude. Both output streams are framed with tlast every FRAME_LEN beats.
- Unlike its predecessor, the whole datapath, including the arithmetic, honours backpressure.

Parameters:
- NCH, 2, number of complex channels per beat.
- DW, 32, width of each signed re/im component; also the magnitude width per channel.
- FRAME_LEN, 4096, output beats per frame; must be a power of two, at least 2.

Ports:
- s00_axis_aclk  in  1  single clock; all logic on the rising edge.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_tdata  in  NCH*2*DW  channel k occupies [k*2DW +: 2DW]; re in the upper DW bits, im in the lower DW bits, both two's complement.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when high together with tvalid.
- m00_axis_tdata  out  NCH*DW  magnitude of channel k at [k*DW +: DW], unsigned.
- m00_axis_tvalid  out  1  magnitude beat valid.
- m00_axis_tlast  out  1  last beat of frame.
- m00_axis_tready  in  1  magnitude sink ready.
- m01_axis_tdata  out  NCH*2*DW  raw input beat, delay-matched to m00.
- m01_axis_tvalid  out  1  raw beat valid.
- m01_axis_tlast  out  1  last beat of frame.
- m01_axis_tready  in  1  raw sink ready.

Behaviour:
- Reset (asynchronous): all stage valids clear; frame counter is 0. Outputs: s00_axis_tready=1, m0x_axis_tvalid=0, m0x_axis_tlast=0, m0x_axis_tdata=0. Internal data registers other than the output stage are not reset.
- Pipeline is a global-enable chain, with adv = !out_valid || (m00_axis_tready && m01_axis_tready).
  - s00_axis_tready = adv. This is combinational from the sink readies; that path is accepted.
  - When adv=1, every stage (valid and data) shifts one step; when adv=0, every stage holds.
  - Bubbles are not compressed.
- Stages, per channel, are:
  - S0: input register.
  - S1: re^2 and im^2, signed DW×DW giving an unsigned 2DW-bit product.
  - S2: sum, unsigned 2DW bits. No overflow is possible, since the maximum is 2^(2DW-1).
  - S3 to S(DW+2): restoring square root, one result bit per stage, MSB first. Each stage carries the partial root, the remainder and the radicand.
  - Output register.
- Latency is DW+4 cycles from an accepted input beat to the output valid, with no stall; this is 36 for DW=32.
- The raw beat travels through a parallel delay line of the same depth and the same enable.
- The m00 and m01 outputs share one valid and one data register stage, so m00_axis_tvalid == m01_axis_tvalid always.
  - A beat retires only when both sinks are ready. Neither output may complete alone.
  - While a beat is stalled, tdata and tlast hold stable.
- Frame counter, log2(FRAME_LEN) bits:
  - Increments on each retired output beat.
  - tlast = valid && (counter == FRAME_LEN-1).
  - Wraps to 0 after the last beat.
- Input tvalid=0 inserts bubbles; bubbles never advance the counter.
- Reset mid-operation drops all in-flight beats, clears the counter, and the next frame starts fresh.

Optional Feature:
- Macro AXIS_MAG_ROUND_EN.
- Defined:
  - An extra final comparison rounds the magnitude to nearest: result = r+1 if sum > r^2+r, else r.
  - The result saturates at 2^DW-1.
  - Latency is unchanged; the comparison is folded into the output register.
- Undefined: the magnitude is floor(sqrt(sum)).

Test Plan:
- Latency and basic value (NCH=2, DW=32): ch0 re=3, im=4 and ch1 re=-5, im=12, both sinks always ready -> m00 ch0=5, ch1=13 exactly 36 cycles after acceptance; m01 equals the input beat.
- Extreme value: re=im=0x80000000 -> floor gives 0xB504F333; with AXIS_MAG_ROUND_EN the result is 0xB504F334.
- Backpressure: a 100-beat ramp with m00_axis_tready and m01_axis_tready toggled independently at random -> no loss or duplication, output order preserved, tdata stable while stalled, and s00_axis_tready low whenever the output is valid and not both sinks are ready.
- Framing (FRAME_LEN=8): 20 beats -> tlast on output beats 7 and 15 on both streams; the counter does not advance on stall or bubble cycles.
- Input bubbles: tvalid asserted on every third cycle -> outputs are correct with the same per-beat latency, and no spurious valid appears.
- Reset mid-stream: assert s00_axis_areset while 10 beats are in flight -> outputs go to their reset values immediately; after release, the first new beat emerges after 36 cycles and tlast first appears on the 8th post-reset beat.
